// File: rtl/icache_lookup_refill_pkg.sv
// Shared types and constants for the instruction-cache lookup/refill block:
// AHB transfer types, cache controller states and memory burst encodings.
package icache_lookup_refill_pkg;

    // AHB HTRANS encodings as produced by transfer_handler.
    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } TRANS_TYPES;

    // Cache controller states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MISS_REQ = 3'd2,
        REFILL   = 3'd3,
        RESP     = 3'd4
    } CACHE_STATE;

    // Memory-side burst encodings (HBURST style).
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] WRAP4  = 3'b010;

    // Words per cache line; refills are always one WRAP4 burst.
    localparam int LINE_WORDS = 4;

    // A transfer carries a real request only when it is NONSEQ or SEQ.
    function automatic logic isActiveTrans(input logic [1:0] trans);
        return (trans == TRANS_NONSEQ) || (trans == TRANS_SEQ);
    endfunction

endpackage

// File: rtl/icache_lookup_refill_if.sv
// Bus bundle between the cache and its environment: the request side coming
// from transfer_handler, the AHB read-data return, and the refill memory port.
interface icache_lookup_refill_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import icache_lookup_refill_pkg::*;

    // Request side (from transfer_handler)
    logic [ADDR_W-1:0]             read_addr;
    logic [$clog2(LINE_WORDS)-1:0] read_addr_offset;
    logic [1:0]                    trans_out;
    logic                          inv;

    // AHB return side
    logic [DATA_W-1:0]             hrdata;
    logic                          hready_out;

    // Refill memory port
    logic                          mem_req;
    logic [ADDR_W-1:0]             mem_addr;
    logic [2:0]                    mem_burst;
    logic                          mem_ready;
    logic [DATA_W-1:0]             mem_rdata;
    logic                          mem_rvalid;

    // The cache itself
    modport slave (
        input  read_addr, read_addr_offset, trans_out, inv,
        input  mem_ready, mem_rdata, mem_rvalid,
        output hrdata, hready_out,
        output mem_req, mem_addr, mem_burst
    );

    // Whoever drives requests and models memory
    modport master (
        output read_addr, read_addr_offset, trans_out, inv,
        output mem_ready, mem_rdata, mem_rvalid,
        input  hrdata, hready_out,
        input  mem_req, mem_addr, mem_burst
    );

endinterface

// File: rtl/icache_lookup_refill_array.sv
// Direct-mapped line storage: per-line valid bit (reset and flash-clearable),
// tag and 4-word data. One word-write port used by refill beats, a line commit
// port that writes the tag and sets valid, and a combinational read port.
module icache_array
    import icache_lookup_refill_pkg::*;
#(
    parameter int LINES   = 16,
    parameter int TAG_W   = 24,
    parameter int DATA_W  = 32,
    localparam int IDX_W  = $clog2(LINES),
    localparam int WORD_W = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [WORD_W-1:0] i_wr_word,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_fill_en,
    input  logic [TAG_W-1:0]  i_fill_tag,
    input  logic              i_fill_valid,
    input  logic [IDX_W-1:0]  i_rd_idx,
    input  logic [WORD_W-1:0] i_rd_word,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES][LINE_WORDS];

    // Valid bits: flash clear takes priority over a line being committed in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_clear) begin
            r_valid <= '0;
        end else if (i_fill_en && i_fill_valid) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tags are written when a line finishes refilling; contents are don't-care until valid.
    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[i_wr_idx] <= i_fill_tag;
        end
    end

    // Data words land one per refill beat, in wrap order chosen by the controller.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[i_wr_idx][i_wr_word] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx][i_rd_word];

endmodule

// File: rtl/icache_lookup_refill.sv
// Direct-mapped instruction cache front end. The tag compare and data read are
// done against the incoming address at the accept edge, so a hit appears on the
// registered hrdata/hready_out in the following (LOOKUP) cycle. A miss issues a
// WRAP4 refill starting at the critical word and returns that word in RESP.
module icache_lookup_refill
    import icache_lookup_refill_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic                   clk,
    input logic                   rst,
    icache_lookup_refill_if.slave bus
);

    localparam int IDX_W  = $clog2(LINES);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int TAG_W  = ADDR_W - 4 - IDX_W;

    // Controller state and registered outputs
    CACHE_STATE        r_state;
    logic              r_hready_out;
    logic [DATA_W-1:0] r_hrdata;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [2:0]        r_mem_burst;

    // Captured request and refill bookkeeping
    logic [TAG_W-1:0]  r_tag;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] r_beat;
    logic [DATA_W-1:0] r_crit;
    logic              r_poison;

    // Incoming request split and array read results
    logic [TAG_W-1:0]  w_req_tag;
    logic [IDX_W-1:0]  w_req_idx;
    logic [WORD_W-1:0] w_req_word;
    logic [TAG_W-1:0]  w_rd_tag;
    logic              w_rd_valid;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_hit;
    logic              w_accept;

    // Refill write controls
    logic              w_wr_en;
    logic [WORD_W-1:0] w_wr_word;
    logic              w_fill_en;
    logic              w_fill_valid;

    // Byte offset bits never select anything; the word comes from read_addr_offset.
    logic              w_unused_addr_bits;

    assign w_req_tag          = bus.read_addr[ADDR_W-1 -: TAG_W];
    assign w_req_idx          = bus.read_addr[4 +: IDX_W];
    assign w_req_word         = bus.read_addr_offset;
    assign w_unused_addr_bits = ^bus.read_addr[3:0];

    assign w_hit    = w_rd_valid && (w_rd_tag == w_req_tag);
    assign w_accept = r_hready_out && isActiveTrans(bus.trans_out);

    // Beats arrive in wrap order starting at the critical word; the 4th beat commits the line.
    assign w_wr_en      = (r_state == REFILL) && bus.mem_rvalid;
    assign w_wr_word    = r_word + r_beat;
    assign w_fill_en    = w_wr_en && (r_beat == WORD_W'(LINE_WORDS - 1));
    assign w_fill_valid = !(r_poison || bus.inv);

    icache_array #(
        .LINES  (LINES),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (bus.inv),
        .i_wr_en      (w_wr_en),
        .i_wr_idx     (r_idx),
        .i_wr_word    (w_wr_word),
        .i_wr_data    (bus.mem_rdata),
        .i_fill_en    (w_fill_en),
        .i_fill_tag   (r_tag),
        .i_fill_valid (w_fill_valid),
        .i_rd_idx     (w_req_idx),
        .i_rd_word    (w_req_word),
        .o_rd_tag     (w_rd_tag),
        .o_rd_valid   (w_rd_valid),
        .o_rd_data    (w_rd_data)
    );

    // Controller: accept/lookup, miss request, refill beat counting and critical-word response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_hready_out <= 1'b1;
            r_hrdata     <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_burst  <= SINGLE;
            r_tag        <= '0;
            r_idx        <= '0;
            r_word       <= '0;
            r_beat       <= '0;
            r_crit       <= '0;
            r_poison     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, LOOKUP, RESP: begin
                    if (r_hready_out) begin
                        if (w_accept) begin
                            r_state      <= LOOKUP;
                            r_tag        <= w_req_tag;
                            r_idx        <= w_req_idx;
                            r_word       <= w_req_word;
                            r_hready_out <= w_hit;
                            if (w_hit) begin
                                r_hrdata <= w_rd_data;
                            end
                        end else begin
                            r_state      <= IDLE;
                            r_hready_out <= 1'b1;
                        end
                    end else begin
                        r_state     <= MISS_REQ;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= {r_tag, r_idx, r_word, 2'b00};
                        r_mem_burst <= WRAP4;
                        r_poison    <= 1'b0;
                    end
                end

                MISS_REQ: begin
                    if (bus.inv) begin
                        r_poison <= 1'b1;
                    end
                    if (bus.mem_ready) begin
                        r_state     <= REFILL;
                        r_mem_req   <= 1'b0;
                        r_mem_burst <= SINGLE;
                        r_beat      <= '0;
                    end
                end

                REFILL: begin
                    if (bus.inv) begin
                        r_poison <= 1'b1;
                    end
                    if (bus.mem_rvalid) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == '0) begin
                            r_crit <= bus.mem_rdata;
                        end
                        if (r_beat == WORD_W'(LINE_WORDS - 1)) begin
                            r_state      <= RESP;
                            r_hready_out <= 1'b1;
                            r_hrdata     <= r_crit;
                        end
                    end
                end

                default: begin
                    r_state      <= IDLE;
                    r_hready_out <= 1'b1;
                end
            endcase
        end
    end

    assign bus.hrdata     = r_hrdata;
    assign bus.hready_out = r_hready_out;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_burst  = r_mem_burst;

endmodule

// File: tb/tb_icache_lookup_refill.sv
// Directed bench for icache_lookup_refill. A line-level cache model plus a
// synthetic memory pattern produce per-cycle expectations; a single negedge
// process compares DUT outputs against them, and a few literal values pin
// the model to hand-computed data.
module tb_icache_lookup_refill;
    import icache_lookup_refill_pkg::*;

    logic clk;
    logic rst;

    icache_lookup_refill_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    icache_lookup_refill #(
        .LINES  (16),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nAssert;
    int nFail;

    // Expected DUT outputs for the current cycle
    bit          chkEn;
    logic        exp_hready;
    logic [31:0] exp_hrdata;
    logic        exp_mreq;
    logic [31:0] exp_maddr;
    logic [2:0]  exp_burst;

    // Cache model: what each line should hold
    bit          modelValid [16];
    logic [23:0] modelTag   [16];
    logic [31:0] modelData  [16][4];
    int          refillCount;

    bit          rdHit;
    logic [31:0] warm [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nAssert++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] trans, input logic [31:0] addr);
        bus.trans_out        = trans;
        bus.read_addr        = addr;
        bus.read_addr_offset = addr[3:2];
    endtask

    task automatic clearModel();
        for (int i = 0; i < 16; i++) modelValid[i] = 1'b0;
    endtask

    // Memory contents: a per-refill generation number plus the word's byte address.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'h5A00_0000 + (32'(refillCount) << 16) + 32'(addr[15:0]);
    endfunction

    // Runs one request through address phase and, on a miss, the whole refill.
    task automatic doRead(input logic [31:0] addr, input int grantDelay, input int invBeat,
                          input int abortBeat, input bit invAtLookup, output bit hit);
        logic [3:0]  idx;
        logic [23:0] tag;
        logic [1:0]  word;
        logic [1:0]  w;
        logic [31:0] d;
        logic [31:0] crit;
        bit          poisoned;
        bit          aborted;
        idx      = addr[7:4];
        tag      = addr[31:8];
        word     = addr[3:2];
        crit     = '0;
        poisoned = 1'b0;
        aborted  = 1'b0;
        hit      = 1'b0;

        applyStimulus(TRANS_NONSEQ, addr);
        exp_hready = 1'b1;
        exp_mreq   = 1'b0;
        exp_burst  = SINGLE;
        stepCycle();
        applyStimulus(TRANS_IDLE, 32'h0);

        if (modelValid[idx] && modelTag[idx] == tag) begin
            hit        = 1'b1;
            exp_hready = 1'b1;
            exp_hrdata = modelData[idx][word];
            if (invAtLookup) bus.inv = 1'b1;
            stepCycle();
            bus.inv = 1'b0;
            if (invAtLookup) clearModel();
        end else begin
            exp_hready = 1'b0;
            stepCycle();
            exp_mreq  = 1'b1;
            exp_maddr = {addr[31:2], 2'b00};
            exp_burst = WRAP4;
            for (int g = 0; g < grantDelay; g++) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'hDEAD_BEEF;
                stepCycle();
            end
            bus.mem_rvalid = 1'b0;
            bus.mem_ready  = 1'b1;
            stepCycle();
            bus.mem_ready = 1'b0;
            exp_mreq      = 1'b0;
            exp_burst     = SINGLE;
            for (int b = 0; b < 4; b++) begin
                if (!aborted) begin
                    if (b == abortBeat) begin
                        aborted        = 1'b1;
                        rst            = 1'b1;
                        exp_hready     = 1'b1;
                        exp_hrdata     = 32'h0;
                        exp_mreq       = 1'b0;
                        exp_burst      = SINGLE;
                        clearModel();
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = 32'hBAD0_0000;
                        stepCycle();
                        stepCycle();
                        rst = 1'b0;
                        stepCycle();
                        bus.mem_rvalid = 1'b0;
                        refillCount++;
                    end else begin
                        w = word + 2'(b);
                        d = memWord({addr[31:4], w, 2'b00});
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = d;
                        modelData[idx][w] = d;
                        if (b == 0) crit = d;
                        if (b == invBeat) begin
                            bus.inv  = 1'b1;
                            poisoned = 1'b1;
                        end
                        stepCycle();
                        bus.mem_rvalid = 1'b0;
                        bus.inv        = 1'b0;
                        if (b == invBeat) clearModel();
                        if (b == 1) stepCycle();
                    end
                end
            end
            if (!aborted) begin
                exp_hready = 1'b1;
                exp_hrdata = crit;
                if (!poisoned) begin
                    modelValid[idx] = 1'b1;
                    modelTag[idx]   = tag;
                end
                refillCount++;
                stepCycle();
            end
        end
    endtask

    // Back-to-back pipelined hits: each address's data appears the cycle after it is presented.
    task automatic hitRun(input logic [31:0] a [4]);
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) applyStimulus((i == 0) ? TRANS_NONSEQ : TRANS_SEQ, a[i]);
            else       applyStimulus(TRANS_IDLE, 32'h0);
            exp_hready = 1'b1;
            if (i > 0) exp_hrdata = modelData[a[i-1][7:4]][a[i-1][3:2]];
            stepCycle();
        end
    endtask

    // Per-cycle comparison of every output against the current expectation.
    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("hready_out", 32'(bus.hready_out), 32'(exp_hready));
            checkOutput("hrdata", bus.hrdata, exp_hrdata);
            checkOutput("mem_req", 32'(bus.mem_req), 32'(exp_mreq));
            checkOutput("mem_burst", 32'(bus.mem_burst), 32'(exp_burst));
            if (exp_mreq) checkOutput("mem_addr", bus.mem_addr, exp_maddr);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nAssert = 0;
        nFail = 0;
        chkEn = 1'b0;
        refillCount = 0;
        rst = 1'b0;
        bus.trans_out = TRANS_IDLE;
        bus.read_addr = '0;
        bus.read_addr_offset = '0;
        bus.inv = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_rvalid = 1'b0;
        clearModel();
        exp_hready = 1'b1;
        exp_hrdata = 32'h0;
        exp_mreq = 1'b0;
        exp_maddr = 32'h0;
        exp_burst = SINGLE;

        #2 rst = 1'b1;
        chkEn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_mem_addr", bus.mem_addr, 32'h0);
        checkOutput("reset_hready", 32'(bus.hready_out), 32'h1);
        rst = 1'b0;
        stepCycle();

        $display("[TB] cold miss to 0x108");
        doRead(32'h0000_0108, 1, -1, -1, 1'b0, rdHit);
        checkOutput("cold_is_miss", 32'(rdHit), 32'h0);
        checkOutput("cold_crit_A", bus.hrdata, 32'h5A00_0108);
        checkOutput("model_word0_C", modelData[0][0], 32'h5A00_0100);

        $display("[TB] warm hits 0x100..0x10C");
        warm = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 32'h0000_010C};
        hitRun(warm);
        checkOutput("warm_last_B", bus.hrdata, 32'h5A00_010C);

        $display("[TB] BUSY and IDLE transfers");
        applyStimulus(TRANS_BUSY, 32'h0000_0308);
        repeat (3) stepCycle();
        applyStimulus(TRANS_IDLE, 32'h0000_0308);
        stepCycle();
        applyStimulus(TRANS_IDLE, 32'h0);
        doRead(32'h0000_0104, 0, -1, -1, 1'b0, rdHit);
        checkOutput("after_busy_hit", 32'(rdHit), 32'h1);
        checkOutput("after_busy_D", bus.hrdata, 32'h5A00_0104);

        $display("[TB] conflict on index 0");
        doRead(32'h0000_0208, 0, -1, -1, 1'b0, rdHit);
        checkOutput("conflict_miss", 32'(rdHit), 32'h0);
        checkOutput("conflict_crit", bus.hrdata, 32'h5A01_0208);
        doRead(32'h0000_0108, 2, -1, -1, 1'b0, rdHit);
        checkOutput("conflict_back_miss", 32'(rdHit), 32'h0);
        checkOutput("conflict_back_crit", bus.hrdata, 32'h5A02_0108);

        $display("[TB] invalidate during refill");
        doRead(32'h0000_001C, 1, 2, -1, 1'b0, rdHit);
        checkOutput("poison_crit", bus.hrdata, 32'h5A03_001C);
        doRead(32'h0000_001C, 0, -1, -1, 1'b0, rdHit);
        checkOutput("poison_then_miss", 32'(rdHit), 32'h0);

        $display("[TB] invalidate coinciding with a hit");
        doRead(32'h0000_0018, 0, -1, -1, 1'b1, rdHit);
        checkOutput("inv_lookup_hit", 32'(rdHit), 32'h1);
        checkOutput("inv_lookup_data", bus.hrdata, 32'h5A04_0018);
        doRead(32'h0000_0018, 0, -1, -1, 1'b0, rdHit);
        checkOutput("inv_lookup_then_miss", 32'(rdHit), 32'h0);

        $display("[TB] reset during refill");
        doRead(32'h0000_0040, 1, -1, 2, 1'b0, rdHit);
        doRead(32'h0000_0018, 0, -1, -1, 1'b0, rdHit);
        checkOutput("after_reset_miss", 32'(rdHit), 32'h0);
        checkOutput("after_reset_crit", bus.hrdata, 32'h5A07_0018);

        stepCycle();
        chkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/icache_lookup_refill.md
Name: icache_lookup_refill

Overview:
- Sits directly downstream of transfer_handler; consumes its registered read_addr, read_addr_offset and trans_out.
- Holds a direct-mapped instruction cache of 4-word lines (tag, valid and data in flops).
- Returns hrdata/hready_out to the AHB slave side.
- On a miss, issues a line refill to the memory port as a WRAP4 burst starting at the critical word.

Parameters:
- LINES, 16, number of cache lines (power of 2, ≥2); IDX_W = log2(LINES).
- ADDR_W, 32, address width.
- DATA_W, 32, word width.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous reset, active-high.
- read_addr  in  32  request byte address from transfer_handler.
- read_addr_offset  in  2  word index within the line (equals read_addr[3:2]).
- trans_out  in  2  TRANS_TYPES from transfer_handler.
- inv  in  1  flash-invalidate pulse.
- hrdata  out  32  read data to the AHB master.
- hready_out  out  1  high when the slave can accept a request / the data phase completes.
- mem_req  out  1  refill request, held until granted.
- mem_addr  out  32  line-aligned refill address plus critical-word offset: {tag, index, offset, 2'b00}.
- mem_burst  out  3  constant WRAP4 (3'b010) while mem_req is high, else SINGLE.
- mem_ready  in  1  memory grant; mem_req is dropped the cycle after it is seen.
- mem_rdata  in  32  refill data.
- mem_rvalid  in  1  refill data valid, one word per beat.

Behaviour:
- Reset state: state=IDLE, hready_out=1, hrdata=0, mem_req=0, mem_addr=0, mem_burst=SINGLE, all valid bits=0, beat counter=0. Tag and data arrays are not reset.
- Address split: tag=read_addr[31:4+IDX_W], index=read_addr[4+IDX_W-1:4], word=read_addr_offset. read_addr[1:0] is ignored.
- Accept rule: a request is captured on a posedge when trans_out is NONSEQ or SEQ and hready_out=1. IDLE or BUSY captures nothing and leaves the state unchanged.
- IDLE: on accept, register the request and go to LOOKUP.
- LOOKUP: hit = valid[idx] && tag match.
  - Hit: hready_out=1 and hrdata=data[idx][word] in this cycle, so hit latency is 1 cycle after the address phase. A new request may be accepted in the same cycle (back-to-back hits, stay in LOOKUP). With no new request, go to IDLE.
  - Miss: hready_out=0, go to MISS_REQ.
- MISS_REQ: mem_req=1, mem_addr={tag,idx,word,2'b00}, mem_burst=WRAP4, hready_out=0. When mem_ready=1, go to REFILL with beat=0.
- REFILL: each mem_rvalid writes mem_rdata into data[idx][(word+beat) mod 4] and increments beat (2-bit, wraps).
  - On the 4th beat: write the tag, set valid[idx] (unless the poison flag is set), go to RESP.
  - mem_rvalid outside REFILL is ignored.
- RESP: hready_out=1, hrdata=data of the critical word (captured on beat 0), go to IDLE. A request presented in this cycle is accepted (go to LOOKUP).
- hrdata holds its last value whenever hready_out=0 or there is no response.
- Invalidate:
  - inv clears all valid bits on the next posedge.
  - If inv arrives during MISS_REQ or REFILL, a poison flag is set; the refill completes and the critical word is returned, but valid is not set.
  - inv coinciding with a LOOKUP hit: the hit data is still returned (the compare uses pre-clear valid).
- Refill to an index holding another tag overwrites it (no replacement choice).
- Async reset mid-refill: immediately returns to IDLE, drops mem_req, clears valid bits. The memory side must tolerate stray beats, which are ignored in IDLE.

Decomposition:
- interface_pkg gains:
  - CACHE_STATE enum {IDLE, LOOKUP, MISS_REQ, REFILL, RESP}.
  - BURST_TYPES constants (SINGLE=3'b000, WRAP4=3'b010).
  - LINE_WORDS=4.
- TRANS_TYPES is reused from the same package.
- One natural sub-module: icache_array (tag/valid/data storage with a write port, a flash-clear, and a combinational read port).

Test Plan:
- Cold miss: rst 3 cycles, then NONSEQ read_addr=32'h0000_0108, offset=2 → mem_req=1, mem_addr=32'h0000_0108, mem_burst=3'b010. Grant, then beats A,B,C,D land at words 2,3,0,1. Then RESP with hrdata=A and hready_out=1; hready_out=0 from LOOKUP through the last beat.
- Warm hit: repeat read_addr=32'h0000_0100 offset 0 → hrdata=C one cycle later, no mem_req. Back-to-back SEQ to 0x104, 0x108, 0x10C → D, A, B on consecutive cycles with hready_out constantly 1.
- Conflict: read 0x0000_0208 (same index 0, new tag) → miss/refill. A following read of 0x108 → miss again.
- IDLE/BUSY: trans_out=BUSY with a valid address → no state change, hready_out stays 1, mem_req stays 0.
- inv during REFILL beat 2 → critical word still returned. The next read of the same address misses (mem_req reasserted).
- rst asserted mid-REFILL → mem_req=0 and hready_out=1 the same cycle. After release, the previously valid address misses.
